// File: rtl/fir_mac_controller.sv
// Sequencer for a serial single-MAC FIR: accepts a sample, writes it to the circular
// buffer, walks all taps newest-first, then holds output_valid until the result is taken.
module fir_mac_controller #(
  parameter int LUT_size = 64,
  localparam int adr_width = $clog2(LUT_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_valid,
  output logic                 input_ready,
  output logic                 sample_wr_en,
  output logic [adr_width-1:0] sample_wr_adr,
  output logic [adr_width-1:0] sample_adr,
  output logic [adr_width-1:0] coef_adr,
  output logic                 acc_clear,
  output logic                 acc_en,
  output logic                 output_valid,
  input  logic                 output_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [adr_width-1:0] LAST = adr_width'(LUT_size - 1);
  localparam logic [adr_width-1:0] ONE  = adr_width'(1);

  state_t               state, state_next;
  logic [adr_width-1:0] wptr, wptr_next;
  logic [adr_width-1:0] tap, tap_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr  <= '0;
      tap   <= '0;
    end else begin
      state <= state_next;
      wptr  <= wptr_next;
      tap   <= tap_next;
    end
  end

  always_comb begin
    state_next    = state;
    wptr_next     = wptr;
    tap_next      = tap;
    input_ready   = 1'b0;
    sample_wr_en  = 1'b0;
    sample_wr_adr = wptr;
    sample_adr    = '0;
    coef_adr      = '0;
    acc_clear     = 1'b0;
    acc_en        = 1'b0;
    output_valid  = 1'b0;

    unique case (state)
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) begin
          sample_wr_en = 1'b1;
          acc_clear    = 1'b1;
          tap_next     = '0;
          state_next   = CALC;
        end
      end
      CALC: begin
        acc_en   = 1'b1;
        coef_adr = tap;
        // Explicit wrap so non-power-of-2 depths never address past LUT_size-1;
        // the sum stays below LUT_size, so modulo-2^adr_width overflow cancels out.
        sample_adr = (wptr >= tap) ? wptr - tap : wptr + (LAST - tap) + ONE;
        if (tap == LAST) begin
          tap_next   = '0;
          state_next = DONE;
        end else begin
          tap_next = tap + ONE;
        end
      end
      DONE: begin
        output_valid = 1'b1;
        if (output_ready) begin
          wptr_next  = (wptr == LAST) ? '0 : wptr + ONE;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_mac_controller.sv
// Self-checking bench: odd tap count (5) with a bench-side sample RAM, coefficient LUT
// and accumulator; a transaction-level model predicts every output on every cycle.
module tb_fir_mac_controller;

  localparam int N  = 5;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, input_valid, output_ready;
  logic          input_ready, sample_wr_en, acc_clear, acc_en, output_valid;
  logic [AW-1:0] sample_wr_adr, sample_adr, coef_adr;
  logic [7:0]    din;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          checking = 1'b0;

  always #5 clk = ~clk;

  fir_mac_controller #(.LUT_size(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .sample_wr_en (sample_wr_en),
    .sample_wr_adr(sample_wr_adr),
    .sample_adr   (sample_adr),
    .coef_adr     (coef_adr),
    .acc_clear    (acc_clear),
    .acc_en       (acc_en),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  // Datapath around the controller: sample RAM, coefficient LUT, accumulator.
  int     coef [N] = '{3, 5, 7, 11, 13};
  int     ram  [N];
  longint acc = 0;
  int     en_cnt = 0;

  always @(posedge clk) begin
    if (sample_wr_en) ram[sample_wr_adr] <= int'(din);
    if (acc_clear) acc <= 0;
    else if (acc_en) acc <= acc + longint'(coef[coef_adr]) * longint'(ram[sample_adr]);
    if (rst || acc_clear) en_cnt <= 0;
    else if (acc_en) en_cnt <= en_cnt + 1;
  end

  // Transaction-level model: m_k counts cycles since acceptance (1..N taps, N+1 result).
  bit     m_busy = 1'b0;
  int     m_k    = 0;
  int     m_wptr = 0;
  int     mram [N];
  longint results [$];

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_wptr <= 0;
    end else if (!m_busy) begin
      if (input_valid) begin
        m_busy       <= 1'b1;
        m_k          <= 1;
        mram[m_wptr] <= int'(din);
      end
    end else if (m_k <= N) begin
      m_k <= m_k + 1;
    end else if (output_ready) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_wptr <= (m_wptr + 1) % N;
    end
  end

  function automatic longint model_y();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(coef[i]) * longint'(mram[(m_wptr - i + N) % N]);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("input_ready",   64'(input_ready),   64'(!m_busy));
      chk("sample_wr_en",  64'(sample_wr_en),  64'(!m_busy && input_valid));
      chk("acc_clear",     64'(acc_clear),     64'(!m_busy && input_valid));
      chk("sample_wr_adr", 64'(sample_wr_adr), 64'(m_wptr));
      chk("acc_en",        64'(acc_en),        64'(m_busy && m_k >= 1 && m_k <= N));
      chk("output_valid",  64'(output_valid),  64'(m_busy && m_k == N + 1));
      chk("coef_adr",      64'(coef_adr),      64'((m_busy && m_k <= N) ? m_k - 1 : 0));
      chk("sample_adr",    64'(sample_adr),
          64'((m_busy && m_k <= N) ? (m_wptr - (m_k - 1) + N) % N : 0));
      chk("clear_en_overlap", 64'(acc_clear & acc_en), 64'(0));
      if (m_busy && m_k == N + 1 && output_ready) begin
        chk("acc_en_count", 64'(en_cnt), 64'(N));
        chk("fir_result",   64'(acc),    64'(model_y()));
        results.push_back(acc);
      end
    end
  end

  task automatic send(input logic [7:0] d, input int stall, input bit capture);
    int unsigned   cyc;
    logic [AW-1:0] adrs [N];
    logic [AW-1:0] exp_adrs [N];
    exp_adrs = '{3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    @(posedge clk); #1;
    din = d; input_valid = 1'b1; output_ready = (stall == 0);
    cyc = 0;
    @(negedge clk);
    while (!input_ready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!input_ready) begin chk("accept_timeout", 64'(input_ready), 64'(1)); return; end
    @(posedge clk); #1;
    input_valid = 1'b0;
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        adrs[i] = sample_adr;
        if (i == N - 1) chk("no_early_valid", 64'(output_valid), 64'(0));
      end
      @(negedge clk);
      chk("latency_valid", 64'(output_valid), 64'(1));
      for (int i = 0; i < N; i++) chk($sformatf("first_sample_adr[%0d]", i), 64'(adrs[i]), 64'(exp_adrs[i]));
    end else begin
      @(negedge clk);
    end
    cyc = 0;
    while (!output_valid && cyc < 200) begin @(negedge clk); cyc++; end
    if (!output_valid) begin chk("result_timeout", 64'(output_valid), 64'(1)); return; end
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        input_valid = i[0];
        @(negedge clk);
        chk("stall_valid_held", 64'(output_valid), 64'(1));
        chk("stall_not_ready",  64'(input_ready),  64'(0));
        chk("stall_no_write",   64'(sample_wr_en), 64'(0));
      end
      @(posedge clk); #1;
      input_valid = 1'b0; output_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      output_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_release", 64'(input_ready), 64'(1));
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint exp_y [6];
    int     t [6];
    int     a [6];
    int     exp_a [6];
    int     got, cyc;
    exp_y = '{3, 5, 7, 11, 13, 0};
    exp_a = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < N; i++) begin ram[i] = 0; mram[i] = 0; end
    rst = 1'b1; input_valid = 1'b0; output_ready = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; checking = 1'b1;
    @(negedge clk);
    chk("reset_input_ready", 64'(input_ready),   64'(1));
    chk("reset_acc_en",      64'(acc_en),        64'(0));
    chk("reset_out_valid",   64'(output_valid),  64'(0));
    chk("reset_wr_adr",      64'(sample_wr_adr), 64'(0));

    // Impulse response: first sample captured in detail, last one stalled in DONE.
    send(8'd1, 0, 1'b1);
    for (int i = 0; i < 4; i++) send(8'd0, 0, 1'b0);
    send(8'd0, 10, 1'b0);
    chk("impulse_count", 64'(results.size()), 64'(6));
    for (int i = 0; i < 6 && i < results.size(); i++)
      chk($sformatf("impulse_y[%0d]", i), 64'(results[i]), 64'(exp_y[i]));

    // Back-to-back throughput after reset: one sample per N+2 cycles, wptr wraps.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    input_valid = 1'b1; output_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 6 && cyc < 100) begin
      din = 8'($urandom);
      @(negedge clk);
      if (sample_wr_en) begin t[got] = cyc; a[got] = int'(sample_wr_adr); got++; end
      cyc++;
      if (got < 6) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 input_valid = 1'b0;
    chk("b2b_count", 64'(got), 64'(6));
    for (int i = 0; i < got; i++) begin
      chk($sformatf("b2b_wr_adr[%0d]", i), 64'(a[i]), 64'(exp_a[i]));
      if (i > 0) chk($sformatf("b2b_period[%0d]", i), 64'(t[i] - t[i-1]), 64'(N + 2));
    end
    repeat (N + 3) @(posedge clk);
    #1;

    // Reset at the second CALC cycle.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(8'd9, 0, 1'b0);
    input_valid = 1'b1; din = 8'd21;
    @(negedge clk);
    chk("pre_reset_wr_adr", 64'(sample_wr_adr), 64'(1));
    @(posedge clk); #1 input_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midcalc_rst_ready",   64'(input_ready),  64'(1));
    chk("midcalc_rst_acc_en",  64'(acc_en),       64'(0));
    chk("midcalc_rst_valid",   64'(output_valid), 64'(0));
    chk("midcalc_rst_coef",    64'(coef_adr),     64'(0));
    chk("midcalc_rst_sadr",    64'(sample_adr),   64'(0));
    @(posedge clk); #1 input_valid = 1'b1; din = 8'd33;
    @(negedge clk);
    chk("post_rst_wr_en",  64'(sample_wr_en),  64'(1));
    chk("post_rst_wr_adr", 64'(sample_wr_adr), 64'(0));
    @(posedge clk); #1 input_valid = 1'b0; output_ready = 1'b1;
    repeat (N + 3) @(posedge clk);
    #1;

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 600; i++) begin
      input_valid  = ($urandom_range(0, 2) != 0);
      output_ready = ($urandom_range(0, 3) != 0);
      din          = 8'($urandom);
      rst          = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
    repeat (N + 3) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
